remote_key_event: RTL and testbench
===================================

Name: remote_key_event

Overview:
- Consumes the NEC IR receiver outputs (data_en, data, repeat_en) and turns them into discrete key events: PRESS, HOLD, REPEAT and RELEASE.
- Runs on sys_clk. The receiver's strobes arrive as slow-domain level pulses (one 0.125 ms tick wide), so this block synchronises them and edge-detects them.
- Events are queued in a small first-word-fall-through FIFO with a valid/ready handshake for the UI/control logic downstream.

Parameters:
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- RELEASE_MS, 120: gap in ms with no repeat code after which the key counts as released.
- HOLD_REPEATS, 3: number of repeat codes after PRESS at which HOLD is emitted. Legal range 1..15.
- FIFO_DEPTH, 4: event queue depth. Must be a power of 2, at least 2.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst, input, 1: asynchronous reset, active-high.
- data_en, input, 1: receiver "new code" strobe, level pulse ≥2 sys_clk wide.
- data, input, 8: receiver command code, stable while data_en is high.
- repeat_en, input, 1: receiver repeat-code strobe, level pulse ≥2 sys_clk wide.
- evt_valid, output, 1: FIFO head holds a valid event.
- evt_ready, input, 1: consumer accepts the head event.
- evt_code, output, 8: key code of the head event.
- evt_type, output, 2: type of the head event. 00 = PRESS, 01 = HOLD, 10 = REPEAT, 11 = RELEASE.
- key_active, output, 1: high while a key is held (FSM not IDLE).
- overflow, output, 1: one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- **Clock and reset:** one clock, sys_clk. Reset is asynchronous and active-high (sys_rst).
- **Reset values:** evt_valid=0, evt_code=0, evt_type=0, key_active=0, overflow=0. FIFO empty, FSM in IDLE, timer=0, rep_cnt=0, held code=0.
- **Synchronisation:**
  - data_en and repeat_en each pass through 2 flops, then a third delay flop.
  - The rising edge (stage2 & ~stage3) gives a one-cycle new_ev or rep_ev.
  - data is sampled raw in the new_ev cycle; it has been stable for ≥2 cycles by then.
- **Latency:**
  - An edge on data_en sampled at clock edge N produces evt_valid at edge N+3, if the FIFO was empty.
  - The head is visible combinationally from the FIFO (first-word-fall-through).
- **Release timer:**
  - RELEASE_CNT = CLK_FREQ/1000*RELEASE_MS; counter width is clog2(RELEASE_CNT+1).
  - The timer clears on any new_ev or rep_ev, and increments while the FSM is in PRESSED or HELD.
  - Timeout fires when timer == RELEASE_CNT-1.
- **FSM states:** IDLE, PRESSED, HELD, SWAP.
  - **IDLE:**
    - new_ev → push PRESS(data), latch code, rep_cnt=0, go to PRESSED.
    - rep_ev is ignored (orphan repeat).
  - **PRESSED:**
    - rep_ev → rep_cnt+1, timer clear.
    - If rep_cnt+1 == HOLD_REPEATS, push HOLD(code) and go to HELD; otherwise no push.
  - **HELD:** rep_ev → push REPEAT(code), timer clear.
  - **PRESSED/HELD, new_ev:**
    - Push RELEASE(old code), latch the new code, go to SWAP.
    - This applies even if the new code equals the old one.
  - **SWAP (one cycle):** push PRESS(new code), rep_cnt=0, go to PRESSED.
  - **PRESSED/HELD, timeout:** push RELEASE(code), go to IDLE.
  - **Priority in one cycle:** new_ev over rep_ev over timeout. At most one push per cycle.
- **rep_cnt:** 4 bits, saturating; it is not used in HELD.
- **FIFO:**
  - pop = evt_valid & evt_ready.
  - Push when full is accepted only if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow pulses for 1 cycle. The FSM still advances as if the push succeeded.
  - Simultaneous push and pop when empty: the write is stored and evt_valid=1 next cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.
- **key_active:** registered; high in PRESSED, HELD and SWAP.
- **Reset mid-operation:**
  - sys_rst flushes the FIFO and returns the FSM to IDLE.
  - No RELEASE is emitted for a key held at reset.
  - Pulses already in the sync flops are discarded.

Test Plan:
1. **Single press, release timeout.** CLK_FREQ=50e6, RELEASE_MS=1 (sim override). data=0x45, data_en high 6250 cycles.
   - PRESS/0x45 with evt_valid at edge+3.
   - RELEASE/0x45 exactly 50000 cycles after the edge.
   - key_active 1→0 at the release.
2. **Hold and repeat.** PRESS 0x18, then 5 repeat_en pulses spaced 40000 cycles apart (RELEASE_MS=1).
   - Queue: PRESS, HOLD on the 3rd repeat, REPEAT on the 4th and 5th, then RELEASE/0x18 50000 cycles after the last repeat.
3. **Key change.** data_en with 0x45, then 20000 cycles later data_en with 0x46.
   - Consecutive entries RELEASE/0x45 and PRESS/0x46, pushed on adjacent cycles.
   - key_active stays 1 throughout.
4. **Backpressure and overflow.** evt_ready=0; PRESS 0x07 plus 5 repeats (HOLD_REPEATS=1) gives 6 events.
   - 4 stored: PRESS, HOLD, REPEAT, REPEAT.
   - overflow pulses twice.
   - Then evt_ready=1 drains those 4 in order, followed by RELEASE.
5. **Orphan repeat.** repeat_en pulse while in IDLE → no event, key_active stays 0.
6. **Reset mid-hold.** sys_rst asserted while in HELD with 2 queued events.
   - evt_valid, key_active and overflow drop immediately.
   - After deassert, the next data_en 0x45 yields a single PRESS/0x45.

Source files
------------

// File: rtl/remote_key_event.sv
`default_nettype none
// ============================================================================
// Module   : remote_key_event
// Brief    : Turns NEC receiver strobes into PRESS/HOLD/REPEAT/RELEASE key
//            events, queued in a first-word-fall-through FIFO with a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module remote_key_event #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int RELEASE_MS   = 120,
    parameter int HOLD_REPEATS = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       data_en,
    input  logic [7:0] data,
    input  logic       repeat_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic [1:0] evt_type,
    output logic       key_active,
    output logic       overflow
);

    localparam int RELEASE_CNT = CLK_FREQ / 1000 * RELEASE_MS;
    localparam int TW          = $clog2(RELEASE_CNT + 1);
    localparam int AW          = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(RELEASE_CNT - 1);
    localparam logic [4:0]    HOLD_VAL    = 5'(HOLD_REPEATS);

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_HOLD    = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2,
        SWAP    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchronisers: two flops of synchronisation plus a delay flop
    // ------------------------------------------------------------------
    logic [2:0] den_sync;
    logic [2:0] rep_sync;
    logic       new_ev;
    logic       rep_ev;

    // Shift both receiver strobes through their synchroniser chains
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            den_sync <= 3'b000;
            rep_sync <= 3'b000;
        end else begin
            den_sync <= {den_sync[1:0], data_en};
            rep_sync <= {rep_sync[1:0], repeat_en};
        end
    end

    assign new_ev = den_sync[1] & ~den_sync[2];
    assign rep_ev = rep_sync[1] & ~rep_sync[2];

    // ------------------------------------------------------------------
    // Key FSM with release timer; the push request is registered so the
    // FIFO write lands one cycle after the decision.
    // ------------------------------------------------------------------
    state_t      state, state_next;
    logic [7:0]  code, code_next;
    logic [3:0]  rep_cnt, rep_cnt_next;
    logic [TW-1:0] timer, timer_next;
    logic        push, push_next;
    logic [1:0]  push_type, push_type_next;
    logic [7:0]  push_code, push_code_next;
    logic        timeout;
    logic [3:0]  rep_inc;

    assign timeout = (timer == TIMEOUT_VAL);
    assign rep_inc = (rep_cnt == 4'hF) ? rep_cnt : rep_cnt + 4'd1;

    // Register FSM state, held key, counters and the pending push
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            code       <= 8'h00;
            rep_cnt    <= 4'h0;
            timer      <= '0;
            push       <= 1'b0;
            push_type  <= EVT_PRESS;
            push_code  <= 8'h00;
            key_active <= 1'b0;
        end else begin
            state      <= state_next;
            code       <= code_next;
            rep_cnt    <= rep_cnt_next;
            timer      <= timer_next;
            push       <= push_next;
            push_type  <= push_type_next;
            push_code  <= push_code_next;
            key_active <= (state_next != IDLE);
        end
    end

    // Next-state logic: new code beats repeat code beats timeout
    always_comb begin
        state_next     = state;
        code_next      = code;
        rep_cnt_next   = rep_cnt;
        timer_next     = timer;
        push_next      = 1'b0;
        push_type_next = EVT_PRESS;
        push_code_next = code;

        if (new_ev || rep_ev) begin
            timer_next = '0;
        end else if (state == PRESSED || state == HELD) begin
            timer_next = timer + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (new_ev) begin
                    push_next      = 1'b1;
                    push_type_next = EVT_PRESS;
                    push_code_next = data;
                    code_next      = data;
                    rep_cnt_next   = 4'h0;
                    state_next     = PRESSED;
                end
            end
            PRESSED, HELD: begin
                if (new_ev) begin
                    // Any new code (even the same one) is a release + press
                    push_next      = 1'b1;
                    push_type_next = EVT_RELEASE;
                    push_code_next = code;
                    code_next      = data;
                    state_next     = SWAP;
                end else if (rep_ev) begin
                    if (state == PRESSED) begin
                        rep_cnt_next = rep_inc;
                        if (({1'b0, rep_cnt} + 5'd1) == HOLD_VAL) begin
                            push_next      = 1'b1;
                            push_type_next = EVT_HOLD;
                            state_next     = HELD;
                        end
                    end else begin
                        push_next      = 1'b1;
                        push_type_next = EVT_REPEAT;
                    end
                end else if (timeout) begin
                    push_next      = 1'b1;
                    push_type_next = EVT_RELEASE;
                    state_next     = IDLE;
                end
            end
            SWAP: begin
                push_next      = 1'b1;
                push_type_next = EVT_PRESS;
                rep_cnt_next   = 4'h0;
                state_next     = PRESSED;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Event FIFO, first-word-fall-through, extra pointer MSB for full
    // ------------------------------------------------------------------
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic [9:0]  head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = ~empty & evt_ready;
    assign wr_en    = push & (~full | pop);
    assign overflow = push & full & ~pop;

    // Advance the pointers; reset flushes the queue
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Store the pushed event; storage needs no reset since pointers gate it
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_type, push_code};
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign evt_valid = ~empty;
    assign evt_type  = empty ? 2'b00 : head[9:8];
    assign evt_code  = empty ? 8'h00 : head[7:0];

endmodule

`default_nettype wire

// File: tb/tb_remote_key_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_remote_key_event
// Brief    : Self-checking bench for remote_key_event with a scenario-level
//            event model and randomized codes, repeat counts and gaps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_remote_key_event;

    localparam int CLK_FREQ = 1_000_000;
    localparam int REL_MS   = 1;
    localparam int HOLD     = 3;
    localparam int DEPTH    = 4;
    localparam int C        = CLK_FREQ / 1000 * REL_MS;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_HOLD    = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    logic       sys_clk   = 1'b0;
    logic       sys_rst   = 1'b0;
    logic       data_en   = 1'b0;
    logic [7:0] data      = 8'h00;
    logic       repeat_en = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic [1:0] evt_type;
    logic       key_active;
    logic       overflow;

    remote_key_event #(
        .CLK_FREQ    (CLK_FREQ),
        .RELEASE_MS  (REL_MS),
        .HOLD_REPEATS(HOLD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .data_en   (data_en),
        .data      (data),
        .repeat_en (repeat_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_type  (evt_type),
        .key_active(key_active),
        .overflow  (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] t;
        logic [7:0] c;
        int         at;
    } ev_t;

    ev_t  obs[$];
    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ovf_cnt = 0;
    int   kfall_cnt = 0;
    int   krise_cnt = 0;
    int   kfall_at = 0;
    logic ka_prev = 1'b0;

    // Monitor: log every accepted event with its cycle, count overflow
    // pulses and key_active edges.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            ka_prev = 1'b0;
        end else begin
            if (evt_valid && evt_ready) obs.push_back('{evt_type, evt_code, cyc});
            if (overflow) ovf_cnt++;
            if (ka_prev && !key_active) begin
                kfall_cnt++;
                kfall_at = cyc;
            end
            if (!ka_prev && key_active) krise_cnt++;
            ka_prev = key_active;
        end
    end

    // Reference model: events of one key press followed by n repeat codes
    // and a release by timeout.
    function automatic void model_key(input logic [7:0] c, input int n);
        exp_q.push_back('{EV_PRESS, c, 0});
        for (int i = 1; i <= n; i++) begin
            if (i == HOLD)     exp_q.push_back('{EV_HOLD, c, 0});
            else if (i > HOLD) exp_q.push_back('{EV_REPEAT, c, 0});
        end
        exp_q.push_back('{EV_RELEASE, c, 0});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic key_code(input logic [7:0] c, output int t0);
        tick(1);
        data    = c;
        data_en = 1'b1;
        t0      = cyc;
        tick(4);
        data_en = 1'b0;
    endtask

    task automatic rep_pulse(output int t0);
        tick(1);
        repeat_en = 1'b1;
        t0        = cyc;
        tick(4);
        repeat_en = 1'b0;
    endtask

    task automatic test_reset;
        #2 sys_rst = 1'b1;
        tick(3);
        tests++;
        if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", evt_valid); end
        tests++;
        if (evt_code !== 8'h00) begin fails++; $display("FAIL reset_code got %h want 00", evt_code); end
        tests++;
        if (evt_type !== 2'b00) begin fails++; $display("FAIL reset_type got %b want 00", evt_type); end
        tests++;
        if (key_active !== 1'b0) begin fails++; $display("FAIL reset_key_active got %b want 0", key_active); end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
        sys_rst = 1'b0;
        tick(5);
    endtask

    task automatic test_single_press;
        int t0;
        logic [7:0] c;
        c = 8'($urandom);
        obs.delete(); exp_q.delete();
        model_key(c, 0);
        key_code(c, t0);
        tick(C + 50);
        tests++;
        if (obs.size() != exp_q.size()) begin fails++; $display("FAIL single_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs.size() || obs[i].t !== exp_q[i].t || obs[i].c !== exp_q[i].c) begin
                fails++;
                $display("FAIL single[%0d] got type %0d code %h want type %0d code %h", i, obs[i].t, obs[i].c, exp_q[i].t, exp_q[i].c);
            end
        end
        if (obs.size() == 2) begin
            tests++;
            if (obs[0].at != t0 + 4) begin fails++; $display("FAIL single_latency got %0d want %0d", obs[0].at - t0, 4); end
            tests++;
            if (obs[1].at - obs[0].at != C) begin fails++; $display("FAIL single_release_time got %0d want %0d", obs[1].at - obs[0].at, C); end
            tests++;
            if (kfall_at != obs[1].at - 1) begin fails++; $display("FAIL single_key_active_fall got %0d want %0d", kfall_at, obs[1].at - 1); end
        end
    endtask

    task automatic test_hold_repeat;
        int t0, tr, n;
        logic [7:0] c;
        for (int it = 0; it < 3; it++) begin
            c = 8'($urandom);
            n = (it == 0) ? 5 : $urandom_range(0, 6);
            obs.delete(); exp_q.delete();
            model_key(c, n);
            key_code(c, t0);
            tr = t0;
            for (int j = 0; j < n; j++) begin
                tick($urandom_range(150, 800));
                rep_pulse(tr);
            end
            tick(C + 50);
            tests++;
            if (obs.size() != exp_q.size()) begin fails++; $display("FAIL hold_count it%0d n=%0d got %0d want %0d", it, n, obs.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (i >= obs.size() || obs[i].t !== exp_q[i].t || obs[i].c !== exp_q[i].c) begin
                    fails++;
                    $display("FAIL hold[%0d] it%0d got type %0d code %h want type %0d code %h", i, it, obs[i].t, obs[i].c, exp_q[i].t, exp_q[i].c);
                end
            end
            if (n >= HOLD && obs.size() == exp_q.size()) begin
                tests++;
                if (obs[obs.size()-2].at != tr + 4) begin fails++; $display("FAIL hold_last_rep_latency got %0d want 4", obs[obs.size()-2].at - tr); end
                tests++;
                if (obs[obs.size()-1].at - obs[obs.size()-2].at != C) begin
                    fails++;
                    $display("FAIL hold_release_time got %0d want %0d", obs[obs.size()-1].at - obs[obs.size()-2].at, C);
                end
            end
        end
    endtask

    task automatic test_key_change;
        int t0, t1, falls;
        logic [7:0] a, b;
        a = 8'($urandom);
        b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
        obs.delete(); exp_q.delete();
        exp_q.push_back('{EV_PRESS, a, 0});
        exp_q.push_back('{EV_RELEASE, a, 0});
        exp_q.push_back('{EV_PRESS, b, 0});
        exp_q.push_back('{EV_RELEASE, b, 0});
        falls = kfall_cnt;
        key_code(a, t0);
        tick(300);
        key_code(b, t1);
        tick(C + 50);
        tests++;
        if (obs.size() != exp_q.size()) begin fails++; $display("FAIL change_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs.size() || obs[i].t !== exp_q[i].t || obs[i].c !== exp_q[i].c) begin
                fails++;
                $display("FAIL change[%0d] got type %0d code %h want type %0d code %h", i, obs[i].t, obs[i].c, exp_q[i].t, exp_q[i].c);
            end
        end
        if (obs.size() == 4) begin
            tests++;
            if (obs[1].at != t1 + 4) begin fails++; $display("FAIL change_release_latency got %0d want 4", obs[1].at - t1); end
            tests++;
            if (obs[2].at - obs[1].at != 1) begin fails++; $display("FAIL change_adjacent got %0d want 1", obs[2].at - obs[1].at); end
            tests++;
            if (obs[3].at - obs[2].at != C) begin fails++; $display("FAIL change_release_time got %0d want %0d", obs[3].at - obs[2].at, C); end
        end
        tests++;
        if (kfall_cnt - falls != 1) begin fails++; $display("FAIL change_key_active_falls got %0d want 1", kfall_cnt - falls); end
    endtask

    task automatic test_backpressure;
        int t0, tr, ovf0, pushed;
        ev_t full_seq[$];
        obs.delete(); exp_q.delete();
        model_key(8'h07, 7);
        full_seq = exp_q;
        // With the consumer stalled only the first DEPTH events before the
        // release fit; the rest are dropped, then the release follows.
        pushed = full_seq.size() - 1;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(full_seq[i]);
        exp_q.push_back(full_seq[full_seq.size()-1]);
        ovf0 = ovf_cnt;
        evt_ready = 1'b0;
        key_code(8'h07, t0);
        for (int j = 0; j < 7; j++) begin
            tick(100);
            rep_pulse(tr);
        end
        tick(20);
        tests++;
        if (ovf_cnt - ovf0 != pushed - DEPTH) begin fails++; $display("FAIL bp_overflow got %0d want %0d", ovf_cnt - ovf0, pushed - DEPTH); end
        tests++;
        if (evt_valid !== 1'b1 || evt_type !== EV_PRESS || evt_code !== 8'h07) begin
            fails++;
            $display("FAIL bp_head got valid %b type %0d code %h want 1 0 07", evt_valid, evt_type, evt_code);
        end
        evt_ready = 1'b1;
        tick(C + 50);
        tests++;
        if (obs.size() != exp_q.size()) begin fails++; $display("FAIL bp_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs.size() || obs[i].t !== exp_q[i].t || obs[i].c !== exp_q[i].c) begin
                fails++;
                $display("FAIL bp[%0d] got type %0d code %h want type %0d code %h", i, obs[i].t, obs[i].c, exp_q[i].t, exp_q[i].c);
            end
        end
    endtask

    task automatic test_orphan;
        int tr, rises;
        obs.delete();
        rises = krise_cnt;
        rep_pulse(tr);
        tick(50);
        tests++;
        if (obs.size() != 0) begin fails++; $display("FAIL orphan_events got %0d want 0", obs.size()); end
        tests++;
        if (krise_cnt != rises) begin fails++; $display("FAIL orphan_key_active got %0d rises want 0", krise_cnt - rises); end
        tests++;
        if (evt_valid !== 1'b0) begin fails++; $display("FAIL orphan_valid got %b want 0", evt_valid); end
    endtask

    task automatic test_reset_mid_hold;
        int t0, tr;
        logic [7:0] c;
        c = 8'($urandom);
        evt_ready = 1'b0;
        key_code(c, t0);
        for (int j = 0; j < HOLD; j++) begin
            tick(100);
            rep_pulse(tr);
        end
        tick(20);
        tests++;
        if (evt_valid !== 1'b1 || key_active !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre got valid %b key_active %b want 1 1", evt_valid, key_active);
        end
        #2 sys_rst = 1'b1;
        #1;
        tests++;
        if (evt_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", evt_valid); end
        tests++;
        if (key_active !== 1'b0) begin fails++; $display("FAIL rst_key_active got %b want 0", key_active); end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow got %b want 0", overflow); end
        tick(3);
        sys_rst   = 1'b0;
        evt_ready = 1'b1;
        tick(5);
        obs.delete(); exp_q.delete();
        model_key(8'h45, 0);
        key_code(8'h45, t0);
        tick(C + 50);
        tests++;
        if (obs.size() != exp_q.size()) begin fails++; $display("FAIL rst_after_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= obs.size() || obs[i].t !== exp_q[i].t || obs[i].c !== exp_q[i].c) begin
                fails++;
                $display("FAIL rst_after[%0d] got type %0d code %h want type %0d code %h", i, obs[i].t, obs[i].c, exp_q[i].t, exp_q[i].c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_key_change();
        test_backpressure();
        test_orphan();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
